// File: rtl/conv_kxk_stream.sv
// -----------------------------------------------------------------------------
// conv_kxk_stream
// Streaming KSIZE x KSIZE convolution over a WIDTH x HEIGHT raster image.
// One pixel is accepted per cycle when valid_in is high. KSIZE-1 line buffers
// and a KSIZE x KSIZE window register form the neighbourhood. CH_NUM output
// channels are computed in parallel. Each channel uses runtime-loadable signed
// weights, followed by an arithmetic shift, optional ReLU and saturation.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   valid_in     in_data valid, pixel accepted this cycle
//   in_data      unsigned pixel, raster order
//   w_we         weight write enable
//   w_addr       weight index = ch*KSIZE*KSIZE + r*KSIZE + c
//   w_data       signed weight
//   relu_en      clamp negative results to zero
//   conv_out     CH_NUM packed signed results, ch0 in the LSBs
//   valid_out    conv_out valid this cycle
//   frame_done   pulses with the final window of a frame
// -----------------------------------------------------------------------------
module conv_kxk_stream #(
  parameter int WIDTH    = 28,
  parameter int HEIGHT   = 28,
  parameter int DATA_BIT = 8,
  parameter int KSIZE    = 5,
  parameter int CH_NUM   = 3,
  parameter int W_BIT    = 8,
  parameter int OUT_BIT  = 12,
  parameter int SHIFT    = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     valid_in,
  input  logic [DATA_BIT-1:0]                      in_data,
  input  logic                                     w_we,
  input  logic [$clog2(CH_NUM*KSIZE*KSIZE)-1:0]    w_addr,
  input  logic [W_BIT-1:0]                         w_data,
  input  logic                                     relu_en,
  output logic [CH_NUM*OUT_BIT-1:0]                conv_out,
  output logic                                     valid_out,
  output logic                                     frame_done
);

  localparam int KK     = KSIZE * KSIZE;
  localparam int NW     = CH_NUM * KK;
  localparam int CW     = $clog2(WIDTH);
  localparam int RW     = $clog2(HEIGHT);
  localparam int PROD_W = DATA_BIT + 1 + W_BIT;
  localparam int ACC_W  = PROD_W + $clog2(KK);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(KSIZE - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_BIT+1){1'b0}}, {(OUT_BIT-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [OUT_BIT-1:0] shift_relu_sat(
    input logic signed [ACC_W-1:0] acc,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] s;
    s = acc >>> SHIFT;
    if (relu && (s < 0))  return '0;
    if (s > SAT_MAX)      return SAT_MAX[OUT_BIT-1:0];
    if (s < SAT_MIN)      return SAT_MIN[OUT_BIT-1:0];
    return s[OUT_BIT-1:0];
  endfunction

  logic [CW-1:0]             col;
  logic [RW-1:0]             row;
  logic [DATA_BIT-1:0]       lb      [KSIZE-1][WIDTH];
  logic [DATA_BIT-1:0]       win     [KSIZE][KSIZE];
  logic [DATA_BIT-1:0]       col_vec [KSIZE];
  logic signed [W_BIT-1:0]   wts     [NW];
  logic signed [PROD_W-1:0]  prod_c  [CH_NUM][KK];
  logic signed [PROD_W-1:0]  prod_p1 [CH_NUM][KK];
  logic signed [ACC_W-1:0]   sum_c   [CH_NUM];
  logic signed [ACC_W-1:0]   sum_p2  [CH_NUM];
  logic                      vld_p0, vld_p1, vld_p2;
  logic                      last_p0, last_p1, last_p2;

  // Column entering the window: row 0 is the oldest line, row KSIZE-1 is the
  // live pixel. lb[i] holds the line i+1 rows above the current one.
  always_comb begin
    for (int r = 0; r < KSIZE - 1; r++) col_vec[r] = lb[KSIZE-2-r][col];
    col_vec[KSIZE-1] = in_data;
  end

  // ---- Stage 0: accept pixel, window shift, raster counters ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++) win[r][c] <= '0;
    end else begin
      // Windows wrapping into the previous row are excluded by the col test.
      vld_p0  <= valid_in && (row >= ROW_WIN) && (col >= COL_WIN);
      last_p0 <= valid_in && (row == ROW_LAST) && (col == COL_LAST);
      if (valid_in) begin
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE - 1; c++) win[r][c] <= win[r][c+1];
          win[r][KSIZE-1] <= col_vec[r];
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Line buffers carry no reset; stale contents never reach a valid window.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb[0][col] <= in_data;
      for (int i = 1; i < KSIZE - 1; i++) lb[i][col] <= lb[i-1][col];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) wts[i] <= '0;
    end else if (w_we && (32'(w_addr) < NW)) begin
      wts[w_addr] <= w_data;
    end
  end

  // ---- Stage 1: unsigned pixel x signed weight ----
  always_comb begin
    for (int ch = 0; ch < CH_NUM; ch++)
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++)
          prod_c[ch][r*KSIZE+c] = PROD_W'($signed({1'b0, win[r][c]}))
                                * PROD_W'(wts[ch*KK + r*KSIZE + c]);
  end

  always_ff @(posedge clk) prod_p1 <= prod_c;

  // ---- Stage 2: sum of all window products per channel ----
  always_comb begin
    for (int ch = 0; ch < CH_NUM; ch++) begin
      sum_c[ch] = '0;
      for (int t = 0; t < KK; t++) sum_c[ch] = sum_c[ch] + ACC_W'(prod_p1[ch][t]);
    end
  end

  always_ff @(posedge clk) sum_p2 <= sum_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      last_p1 <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      last_p1 <= last_p0;
      last_p2 <= last_p1;
    end
  end

  // ---- Stage 3: shift, ReLU, saturate; output holds between results ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= vld_p2;
      frame_done <= vld_p2 && last_p2;
      if (vld_p2)
        for (int ch = 0; ch < CH_NUM; ch++)
          conv_out[ch*OUT_BIT +: OUT_BIT] <= shift_relu_sat(sum_p2[ch], relu_en);
    end
  end

endmodule
